// File: rtl/vref_sweep_cal_tx.sv
// rtl/vref_sweep_cal_tx.sv - MBTRAIN TX Vref sweep calibration sequencer
// Handshakes start/end over sideband, sweeps Vref codes and reports per-lane window centres.
module vref_sweep_cal_tx #(
  parameter int NUM_LANES      = 16,
  parameter int VREF_W         = 6,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [3:0]                    i_decoded_sideband_message,
  input  logic                          i_sideband_valid,
  input  logic                          i_busy_negedge_detected,
  input  logic                          i_valid_rx,
  input  logic                          i_mainband_or_valtrain_test,
  input  logic [VREF_W-1:0]             i_vref_min,
  input  logic [VREF_W-1:0]             i_vref_max,
  input  logic [VREF_W-1:0]             i_vref_step,
  input  logic                          i_test_ack,
  input  logic [NUM_LANES-1:0]          i_rx_lanes_result,
  output logic [3:0]                    o_sideband_message,
  output logic                          o_valid_tx,
  output logic                          o_pt_en,
  output logic                          o_mainband_or_valtrain_test,
  output logic [VREF_W-1:0]             o_vref_code,
  output logic [NUM_LANES*VREF_W-1:0]   o_lane_vref,
  output logic [NUM_LANES-1:0]          o_lane_pass,
  output logic                          o_done,
  output logic                          o_timeout
);

  typedef enum logic [2:0] {IDLE, START_REQ, SETTLE, PT_RUN, EVAL, END_REQ, DONE} state_t;

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state, state_next;
  logic [VREF_W-1:0]     vmin, vmax, vstep, step_eff;
  logic [VREF_W:0]       next_code;
  logic [SET_W-1:0]      settle_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [NUM_LANES-1:0]  result, seen;
  logic [VREF_W-1:0]     first_code [NUM_LANES];
  logic [VREF_W-1:0]     last_code  [NUM_LANES];
  logic                  start_resp, end_resp, to_hit, settle_hit, to_exit, req_entry;

  assign start_resp = i_sideband_valid && (i_decoded_sideband_message == 4'b0010);
  assign end_resp   = i_sideband_valid && (i_decoded_sideband_message == 4'b0100);
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign settle_hit = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign step_eff   = (vstep == '0) ? VREF_W'(1) : vstep;
  // One extra bit so a wrap past the top code reads as "beyond max".
  assign next_code  = {1'b0, o_vref_code} + {1'b0, step_eff};

  always_comb begin
    state_next = state;
    to_exit    = 1'b0;
    case (state)
      IDLE:      if (i_en) state_next = START_REQ;
      START_REQ: begin
        if (start_resp) state_next = SETTLE;
        else if (to_hit) begin
          state_next = DONE;
          to_exit    = 1'b1;
        end
      end
      SETTLE:    if (settle_hit) state_next = PT_RUN;
      PT_RUN:    if (i_test_ack) state_next = EVAL;
      EVAL:      state_next = (next_code > {1'b0, vmax}) ? END_REQ : SETTLE;
      END_REQ: begin
        if (end_resp) state_next = DONE;
        else if (to_hit) begin
          state_next = DONE;
          to_exit    = 1'b1;
        end
      end
      DONE:      state_next = DONE;
      default:   state_next = IDLE;
    endcase
  end

  assign req_entry = (state_next != state) && (state_next == START_REQ || state_next == END_REQ);

  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      state                       <= IDLE;
      vmin                        <= '0;
      vmax                        <= '0;
      vstep                       <= '0;
      settle_cnt                  <= '0;
      to_cnt                      <= '0;
      result                      <= '0;
      seen                        <= '0;
      o_vref_code                 <= '0;
      o_mainband_or_valtrain_test <= 1'b0;
      o_valid_tx                  <= 1'b0;
      o_timeout                   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        first_code[i] <= '0;
        last_code[i]  <= '0;
      end
    end else begin
      state <= state_next;
      if (state_next != state) begin
        settle_cnt <= '0;
        to_cnt     <= '0;
      end else begin
        if (state == SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
        if (state == START_REQ || state == END_REQ) to_cnt <= to_cnt + TO_W'(1);
      end
      if (state == IDLE && state_next == START_REQ) begin
        vmin                        <= i_vref_min;
        vmax                        <= i_vref_max;
        vstep                       <= i_vref_step;
        o_mainband_or_valtrain_test <= i_mainband_or_valtrain_test;
      end
      if (state == START_REQ && state_next == SETTLE) o_vref_code <= vmin;
      if (state == EVAL && state_next == SETTLE) o_vref_code <= next_code[VREF_W-1:0];
      if (state == PT_RUN && i_test_ack) result <= i_rx_lanes_result;
      if (state == EVAL) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (result[i]) begin
            if (!seen[i]) first_code[i] <= o_vref_code;
            last_code[i] <= o_vref_code;
            seen[i]      <= 1'b1;
          end
        end
      end
      if (to_exit) o_timeout <= 1'b1;
      // A new request takes priority over a busy-release in the same cycle.
      if (req_entry) o_valid_tx <= 1'b1;
      else if (i_busy_negedge_detected && !i_valid_rx) o_valid_tx <= 1'b0;
    end
  end

  assign o_sideband_message = (state == START_REQ) ? 4'b0001 :
                              (state == END_REQ)   ? 4'b0011 : 4'b0000;
  assign o_pt_en = (state == PT_RUN);
  assign o_done  = (state == DONE);

  always_comb begin
    o_lane_vref = '0;
    o_lane_pass = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (o_done && !o_timeout && seen[i]) begin
        o_lane_vref[i*VREF_W +: VREF_W] =
          VREF_W'(({1'b0, first_code[i]} + {1'b0, last_code[i]}) >> 1);
        o_lane_pass[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vref_sweep_cal_tx.sv
// tb/tb_vref_sweep_cal_tx.sv - directed table-driven bench for vref_sweep_cal_tx
module tb_vref_sweep_cal_tx;
  localparam int NL = 4;
  localparam int VW = 6;
  localparam int ST = 4;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst_n, i_en, i_sideband_valid, i_busy_negedge_detected, i_valid_rx;
  logic          i_mainband_or_valtrain_test, i_test_ack;
  logic [3:0]    i_decoded_sideband_message;
  logic [VW-1:0] i_vref_min, i_vref_max, i_vref_step;
  logic [NL-1:0] i_rx_lanes_result;
  logic [3:0]    o_sideband_message;
  logic          o_valid_tx, o_pt_en, o_mainband_or_valtrain_test, o_done, o_timeout;
  logic [VW-1:0] o_vref_code;
  logic [NL*VW-1:0] o_lane_vref;
  logic [NL-1:0] o_lane_pass;

  int checks = 0;
  int errors = 0;

  vref_sweep_cal_tx #(.NUM_LANES(NL), .VREF_W(VW), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en),
    .i_decoded_sideband_message(i_decoded_sideband_message),
    .i_sideband_valid(i_sideband_valid),
    .i_busy_negedge_detected(i_busy_negedge_detected), .i_valid_rx(i_valid_rx),
    .i_mainband_or_valtrain_test(i_mainband_or_valtrain_test),
    .i_vref_min(i_vref_min), .i_vref_max(i_vref_max), .i_vref_step(i_vref_step),
    .i_test_ack(i_test_ack), .i_rx_lanes_result(i_rx_lanes_result),
    .o_sideband_message(o_sideband_message), .o_valid_tx(o_valid_tx), .o_pt_en(o_pt_en),
    .o_mainband_or_valtrain_test(o_mainband_or_valtrain_test), .o_vref_code(o_vref_code),
    .o_lane_vref(o_lane_vref), .o_lane_pass(o_lane_pass), .o_done(o_done), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0]       vmin, vmax, vstep;
    logic [NL-1:0][63:0] pass_map;
    logic [NL*VW-1:0]    exp_vref;
    logic [NL-1:0]       exp_pass;
    int                  exp_pulses;
    logic [VW-1:0]       exp_first, exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_msg(input logic [3:0] val);
    for (int i = 0; i < 60 && o_sideband_message != val; i++) @(negedge clk);
    chk("wait_msg", 64'(o_sideband_message), 64'(val));
  endtask

  task automatic wait_pt();
    for (int i = 0; i < 60 && !o_pt_en; i++) @(negedge clk);
    chk("wait_pt_en", 64'(o_pt_en), 64'd1);
  endtask

  task automatic send_resp(input logic [3:0] msg);
    i_sideband_valid = 1'b1;
    i_decoded_sideband_message = msg;
    @(negedge clk);
    i_sideband_valid = 1'b0;
    i_decoded_sideband_message = 4'b0000;
  endtask

  task automatic ack(input logic [NL-1:0] res);
    @(negedge clk);
    i_rx_lanes_result = res;
    i_test_ack = 1'b1;
    @(negedge clk);
    i_test_ack = 1'b0;
  endtask

  task automatic sweep(input vec_t v, output int pulses, output logic [VW-1:0] fc, output logic [VW-1:0] lc);
    logic [NL-1:0] res;
    int guard;
    pulses = 0; fc = '0; lc = '0; guard = 0;
    i_vref_min = v.vmin; i_vref_max = v.vmax; i_vref_step = v.vstep;
    i_en = 1'b1;
    wait_msg(4'b0001);
    send_resp(4'b0010);
    while (guard < 2000) begin
      guard++;
      if (o_pt_en) begin
        if (pulses == 0) fc = o_vref_code;
        lc = o_vref_code;
        pulses++;
        for (int l = 0; l < NL; l++) res[l] = v.pass_map[l][o_vref_code];
        ack(res);
      end else if (o_sideband_message == 4'b0011) begin
        send_resp(4'b0100);
        break;
      end else @(negedge clk);
    end
    chk("sweep_bound", 64'(guard < 2000), 64'd1);
  endtask

  int n, pulses;
  logic [VW-1:0] fc, lc;

  initial begin
    vecs[0] = '{6'd0,  6'd7,  6'd1, {64'hFF, 64'h80, 64'h0, 64'h7C},
                {6'd3, 6'd7, 6'd0, 6'd4}, 4'b1101, 8, 6'd0, 6'd7};
    vecs[1] = '{6'd2,  6'd10, 6'd4, {64'h400, 64'h0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF},
                {6'd10, 6'd0, 6'd6, 6'd6}, 4'b1011, 3, 6'd2, 6'd10};
    vecs[2] = '{6'd60, 6'd63, 6'd8, {64'h0, 64'h0, 64'h0, 64'h1000_0000_0000_0000},
                {6'd0, 6'd0, 6'd0, 6'd60}, 4'b0001, 1, 6'd60, 6'd60};
    vecs[3] = '{6'd5,  6'd7,  6'd0, {64'h0, 64'h0, 64'hA0, 64'h40},
                {6'd0, 6'd0, 6'd6, 6'd6}, 4'b0011, 3, 6'd5, 6'd7};
    vecs[4] = '{6'd9,  6'd3,  6'd1, {64'h0, 64'h200, 64'h0, 64'h0},
                {6'd0, 6'd9, 6'd0, 6'd0}, 4'b0100, 1, 6'd9, 6'd9};
    vecs[5] = '{6'd61, 6'd63, 6'd1, {64'hE000_0000_0000_0000, 64'h0, 64'h0, 64'h8000_0000_0000_0000},
                {6'd62, 6'd0, 6'd0, 6'd63}, 4'b1001, 3, 6'd61, 6'd63};

    rst_n = 1'b0; i_en = 1'b0; i_sideband_valid = 1'b0; i_decoded_sideband_message = '0;
    i_busy_negedge_detected = 1'b0; i_valid_rx = 1'b0; i_mainband_or_valtrain_test = 1'b0;
    i_vref_min = '0; i_vref_max = '0; i_vref_step = '0; i_test_ack = 1'b0; i_rx_lanes_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_msg", 64'(o_sideband_message), 64'd0);
    chk("rst_valid_tx", 64'(o_valid_tx), 64'd0);
    chk("rst_pt_en", 64'(o_pt_en), 64'd0);
    chk("rst_code", 64'(o_vref_code), 64'd0);
    chk("rst_lane_vref", 64'(o_lane_vref), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Timeout with no start response, plus valid_tx clear rules and ignored responses.
    i_en = 1'b1;
    wait_msg(4'b0001);
    chk("to_valid_tx_set", 64'(o_valid_tx), 64'd1);
    n = 0;
    i_decoded_sideband_message = 4'b0010; i_sideband_valid = 1'b0;
    i_busy_negedge_detected = 1'b1; i_valid_rx = 1'b1;
    @(negedge clk); n++;
    chk("to_unqualified_resp", 64'(o_sideband_message), 64'd1);
    chk("to_busy_rx_owns", 64'(o_valid_tx), 64'd1);
    i_valid_rx = 1'b0; i_decoded_sideband_message = 4'b0100; i_sideband_valid = 1'b1;
    @(negedge clk); n++;
    chk("to_busy_clear", 64'(o_valid_tx), 64'd0);
    chk("to_wrong_resp", 64'(o_sideband_message), 64'd1);
    i_busy_negedge_detected = 1'b0; i_sideband_valid = 1'b0; i_decoded_sideband_message = '0;
    while (!o_done && n < 5 * TO) begin
      @(negedge clk); n++;
    end
    chk("to_cycles", 64'(n), 64'(TO));
    chk("to_timeout", 64'(o_timeout), 64'd1);
    chk("to_done", 64'(o_done), 64'd1);
    chk("to_pass", 64'(o_lane_pass), 64'd0);
    chk("to_msg", 64'(o_sideband_message), 64'd0);
    i_en = 1'b0;
    @(negedge clk);
    chk("to_clear", 64'({o_done, o_timeout}), 64'd0);

    // Abort mid-PT_RUN after lane1 has passed once; the following sweep must not see it.
    i_vref_min = 6'd0; i_vref_max = 6'd7; i_vref_step = 6'd1; i_en = 1'b1;
    wait_msg(4'b0001);
    send_resp(4'b0010);
    wait_pt();
    ack(4'b1111);
    wait_pt();
    chk("ab_code", 64'(o_vref_code), 64'd1);
    i_en = 1'b0;
    @(negedge clk);
    chk("ab_pt_en", 64'(o_pt_en), 64'd0);
    chk("ab_valid_tx", 64'(o_valid_tx), 64'd0);
    chk("ab_idle", 64'({o_sideband_message, o_vref_code, o_done}), 64'd0);

    for (int k = 0; k < 6; k++) begin
      sweep(vecs[k], pulses, fc, lc);
      chk($sformatf("v%0d_done", k), 64'(o_done), 64'd1);
      chk($sformatf("v%0d_timeout", k), 64'(o_timeout), 64'd0);
      chk($sformatf("v%0d_lane_vref", k), 64'(o_lane_vref), 64'(vecs[k].exp_vref));
      chk($sformatf("v%0d_lane_pass", k), 64'(o_lane_pass), 64'(vecs[k].exp_pass));
      chk($sformatf("v%0d_pulses", k), 64'(pulses), 64'(vecs[k].exp_pulses));
      chk($sformatf("v%0d_first", k), 64'(fc), 64'(vecs[k].exp_first));
      chk($sformatf("v%0d_last", k), 64'(lc), 64'(vecs[k].exp_last));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_hold", k), 64'({o_done, o_lane_pass}), 64'({1'b1, vecs[k].exp_pass}));
      i_en = 1'b0;
      @(negedge clk);
    end

    // END_REQ entry coinciding with busy negedge; stray end response during sweep.
    i_vref_min = 6'd20; i_vref_max = 6'd20; i_vref_step = 6'd1;
    i_mainband_or_valtrain_test = 1'b1; i_en = 1'b1;
    wait_msg(4'b0001);
    chk("sw_mode", 64'(o_mainband_or_valtrain_test), 64'd1);
    send_resp(4'b0010);
    send_resp(4'b0100);
    chk("sw_stray_msg", 64'({o_sideband_message, o_done}), 64'd0);
    wait_pt();
    chk("sw_code", 64'(o_vref_code), 64'd20);
    @(negedge clk);
    i_rx_lanes_result = 4'b0010; i_test_ack = 1'b1;
    @(negedge clk);
    i_test_ack = 1'b0; i_busy_negedge_detected = 1'b1; i_valid_rx = 1'b0;
    @(negedge clk);
    i_busy_negedge_detected = 1'b0;
    chk("sw_end_msg", 64'(o_sideband_message), 64'd3);
    chk("sw_set_wins", 64'(o_valid_tx), 64'd1);
    send_resp(4'b0100);
    chk("sw_done", 64'(o_done), 64'd1);
    chk("sw_lane_vref", 64'(o_lane_vref), 64'({6'd0, 6'd0, 6'd20, 6'd0}));
    chk("sw_lane_pass", 64'(o_lane_pass), 64'd2);
    i_en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
